// File: rtl/gamepad_pkg.sv
// Shared constants, button indices and FSM encoding for the gamepad
// event block.
package gamepad_pkg;

  localparam int N_PADS = 4;
  localparam int N_BTN  = 16;

  localparam int B      = 0;
  localparam int Y      = 1;
  localparam int SELECT = 2;
  localparam int START  = 3;
  localparam int UP     = 4;
  localparam int DOWN   = 5;
  localparam int LEFT   = 6;
  localparam int RIGHT  = 7;
  localparam int A      = 8;
  localparam int X      = 9;
  localparam int L      = 10;
  localparam int R      = 11;

  typedef logic [N_BTN-1:0] btn_t;
  typedef logic [1:0]       pad_idx_t;
  typedef logic [3:0]       btn_idx_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  function automatic btn_idx_t low_bit(input btn_t v);
    btn_idx_t r;
    r = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (v[i]) r = btn_idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/gamepad_events_if.sv
// Button-event handshake: producer (master) presents pad/button/state
// with evt_valid, consumer (slave) accepts with evt_ready.
interface gamepad_events_if;
  import gamepad_pkg::*;

  logic     evt_valid;
  logic     evt_ready;
  pad_idx_t evt_pad;
  btn_idx_t evt_button;
  logic     evt_pressed;

  modport master (
    output evt_valid,
    output evt_pad,
    output evt_button,
    output evt_pressed,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_pad,
    input  evt_button,
    input  evt_pressed,
    output evt_ready
  );

endinterface

// File: rtl/gamepad_debounce.sv
// Per-pad debouncer: 16 stable bits with a frame counter each.
// Ports: clk, rst, frame (strobe), raw[15:0] in; stable[15:0] out.
module gamepad_debounce
  import gamepad_pkg::*;
#(
  parameter int DEBOUNCE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic frame,
  input  btn_t raw,
  output btn_t stable
);

  localparam logic [2:0] LAST = 3'(DEBOUNCE - 1);

  logic [N_BTN-1:0][2:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      cnt    <= '0;
    end else if (frame) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (raw[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          stable[i] <= raw[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/gamepad_events.sv
// Gamepad frame capture, debounce and round-robin button-event queue.
// Ports: clk, rst, gp1..gp4, gp_data_ready in; btn1..btn4, frame_tick out; evt (master).
module gamepad_events
  import gamepad_pkg::*;
#(
  parameter int          DEBOUNCE   = 2,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter logic [15:0] BTN_MASK   = 16'h0FFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      gp1,
  input  logic [15:0]      gp2,
  input  logic [15:0]      gp3,
  input  logic [15:0]      gp4,
  input  logic             gp_data_ready,
  output logic [15:0]      btn1,
  output logic [15:0]      btn2,
  output logic [15:0]      btn3,
  output logic [15:0]      btn4,
  output logic             frame_tick,
  gamepad_events_if.master evt
);

  btn_t gp_w     [N_PADS];
  btn_t raw      [N_PADS];
  btn_t cap_q    [N_PADS];
  btn_t stable   [N_PADS];
  btn_t reported [N_PADS];
  btn_t pend     [N_PADS];

  logic     rdy_q;
  logic     capture;
  state_e   state_q;
  state_e   state_d;
  logic     valid_c;
  logic     any_pend;
  pad_idx_t sel_pad;
  btn_idx_t sel_bit;
  pad_idx_t idx;
  pad_idx_t rr_q;
  pad_idx_t pad_q;
  btn_idx_t bit_q;
  logic     pr_q;
  logic     take;
  logic     acc;

  assign gp_w[0] = gp1;
  assign gp_w[1] = gp2;
  assign gp_w[2] = gp3;
  assign gp_w[3] = gp4;

  assign capture = gp_data_ready & ~rdy_q;

  always_comb begin
    for (int p = 0; p < N_PADS; p++) begin
      raw[p]  = (gp_w[p] ^ {N_BTN{ACTIVE_LOW}}) & BTN_MASK;
      pend[p] = stable[p] ^ reported[p];
    end
  end

  // rdy_q resets high so a level already up at release is not a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q      <= 1'b1;
      frame_tick <= 1'b0;
      for (int p = 0; p < N_PADS; p++) cap_q[p] <= '0;
    end else begin
      rdy_q      <= gp_data_ready;
      frame_tick <= capture;
      if (capture) begin
        for (int p = 0; p < N_PADS; p++) cap_q[p] <= raw[p];
      end
    end
  end

  for (genvar p = 0; p < N_PADS; p++) begin : g_pad
    gamepad_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .frame (frame_tick),
      .raw   (cap_q[p]),
      .stable(stable[p])
    );
  end

  assign btn1 = stable[0];
  assign btn2 = stable[1];
  assign btn3 = stable[2];
  assign btn4 = stable[3];

  // search starts after the last served pad; k=4 wraps to rr_q itself
  always_comb begin
    any_pend = 1'b0;
    sel_pad  = rr_q;
    idx      = '0;
    for (int k = 1; k <= N_PADS; k++) begin
      idx = rr_q + 2'(k);
      if (!any_pend && (|pend[idx])) begin
        any_pend = 1'b1;
        sel_pad  = idx;
      end
    end
    sel_bit = low_bit(pend[sel_pad]);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_pend)      state_d = PRESENT;
      PRESENT: if (evt.evt_ready) state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_c = (state_q == PRESENT);
    take    = (state_q == IDLE) && any_pend;
    acc     = valid_c && evt.evt_ready;
  end

  // event fields load only on IDLE->PRESENT so they hold under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_q <= '0;
      bit_q <= '0;
      pr_q  <= 1'b0;
      rr_q  <= 2'd3;
      for (int p = 0; p < N_PADS; p++) reported[p] <= '0;
    end else begin
      if (take) begin
        pad_q <= sel_pad;
        bit_q <= sel_bit;
        pr_q  <= stable[sel_pad][sel_bit];
      end
      if (acc) begin
        reported[pad_q][bit_q] <= pr_q;
        rr_q                   <= pad_q;
      end
    end
  end

  assign evt.evt_valid   = valid_c;
  assign evt.evt_pad     = pad_q;
  assign evt.evt_button  = bit_q;
  assign evt.evt_pressed = pr_q;

endmodule

// File: tb/tb_gamepad_events.sv
// Self-checking bench for gamepad_events: vector table, corner-case
// sequences and randomized frames against a frame-level reference model.
module tb_gamepad_events;
  import gamepad_pkg::*;

  localparam int          DEB  = 2;
  localparam logic [15:0] MASK = 16'h0FFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] gp1, gp2, gp3, gp4;
  logic        gp_data_ready;
  logic [15:0] btn1, btn2, btn3, btn4;
  logic        frame_tick;

  gamepad_events_if ev ();

  gamepad_events dut (
    .clk          (clk),
    .rst          (rst),
    .gp1          (gp1),
    .gp2          (gp2),
    .gp3          (gp3),
    .gp4          (gp4),
    .gp_data_ready(gp_data_ready),
    .btn1         (btn1),
    .btn2         (btn2),
    .btn3         (btn3),
    .btn4         (btn4),
    .frame_tick   (frame_tick),
    .evt          (ev)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] gpw [4];

  int m_cnt [4][16];
  bit m_st  [4][16];
  bit m_rep [4][16];
  int m_rr;

  typedef struct {
    int          pad;
    logic [15:0] w;
    int          nfr;
    bit          ev;
    logic [1:0]  ep;
    logic [3:0]  eb;
    bit          epr;
    logic [15:0] ebtn;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] get_btn(input int p);
    case (p)
      0:       return btn1;
      1:       return btn2;
      2:       return btn3;
      default: return btn4;
    endcase
  endfunction

  function automatic logic [6:0] cur_evt();
    return {ev.evt_pad, ev.evt_button, ev.evt_pressed};
  endfunction

  task automatic frame();
    gp1 = gpw[0];
    gp2 = gpw[1];
    gp3 = gpw[2];
    gp4 = gpw[3];
    gp_data_ready = 1'b1;
    step();
    gp_data_ready = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    gp_data_ready = 1'b0;
    ev.evt_ready = 1'b0;
    for (int p = 0; p < 4; p++) gpw[p] = 16'hFFFF;
    gp1 = gpw[0];
    gp2 = gpw[1];
    gp3 = gpw[2];
    gp4 = gpw[3];
    step();
    step();
    rst = 1'b0;
    step();
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 16; b++) begin
        m_cnt[p][b] = 0;
        m_st[p][b]  = 1'b0;
        m_rep[p][b] = 1'b0;
      end
    m_rr = 3;
  endtask

  task automatic collect(output bit got, output logic [6:0] e);
    got = 1'b0;
    e   = '0;
    for (int i = 0; i < 6 && !got; i++) begin
      if (ev.evt_valid) begin
        got = 1'b1;
        e   = cur_evt();
      end
      step();
    end
  endtask

  // reference model: frame-level debounce and event selection
  function automatic void m_frame();
    bit r;
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 16; b++) begin
        r = MASK[b] & ~gpw[p][b];
        if (r == m_st[p][b]) begin
          m_cnt[p][b] = 0;
        end else begin
          m_cnt[p][b]++;
          if (m_cnt[p][b] >= DEB) begin
            m_st[p][b]  = r;
            m_cnt[p][b] = 0;
          end
        end
      end
  endfunction

  function automatic void m_next(output bit f, output int p, output int b);
    int pp;
    f = 1'b0;
    p = 0;
    b = 0;
    for (int k = 1; k <= 4; k++) begin
      pp = (m_rr + k) % 4;
      for (int bb = 0; bb < 16; bb++)
        if (!f && m_st[pp][bb] != m_rep[pp][bb]) begin
          f = 1'b1;
          p = pp;
          b = bb;
        end
    end
  endfunction

  function automatic logic [15:0] m_word(input int p);
    logic [15:0] w;
    for (int b = 0; b < 16; b++) w[b] = m_st[p][b];
    return w;
  endfunction

  task automatic drain();
    bit f;
    int p, b;
    int budget;
    budget = 400;
    m_next(f, p, b);
    while (f && budget > 0) begin
      ev.evt_ready = 1'($urandom_range(0, 1));
      if (ev.evt_valid && ev.evt_ready) begin
        chk("rnd_evt", cur_evt(), {p[1:0], b[3:0], m_st[p][b]});
        m_rep[p][b] = m_st[p][b];
        m_rr = p;
        m_next(f, p, b);
      end
      step();
      budget--;
    end
    chk("rnd_drain_done", f, 0);
    ev.evt_ready = 1'b0;
    repeat (3) step();
    chk("rnd_idle", ev.evt_valid, 0);
  endtask

  initial begin
    bit          got;
    logic [6:0]  e;
    int          n, last;
    logic [1:0]  fp [8];
    logic [3:0]  fb [8];

    vecs[0] = '{0, 16'hFFFE, 2, 1, 2'd0, 4'd0,  1'b1, 16'h0001};
    vecs[1] = '{0, 16'hFFFF, 2, 1, 2'd0, 4'd0,  1'b0, 16'h0000};
    vecs[2] = '{1, 16'hFEFF, 1, 0, 2'd0, 4'd0,  1'b0, 16'h0000};
    vecs[3] = '{1, 16'hFFFF, 1, 0, 2'd0, 4'd0,  1'b0, 16'h0000};
    vecs[4] = '{2, 16'h0FFF, 3, 0, 2'd0, 4'd0,  1'b0, 16'h0000};
    vecs[5] = '{2, 16'hF7FF, 2, 1, 2'd2, 4'd11, 1'b1, 16'h0800};
    vecs[6] = '{3, 16'hFFEF, 1, 0, 2'd0, 4'd0,  1'b0, 16'h0000};
    vecs[7] = '{3, 16'hFFEF, 1, 1, 2'd3, 4'd4,  1'b1, 16'h0010};

    // reset state, checked while rst is still asserted
    rst = 1'b1;
    gp_data_ready = 1'b0;
    ev.evt_ready = 1'b0;
    gp1 = 16'hFFFF; gp2 = 16'hFFFF; gp3 = 16'hFFFF; gp4 = 16'hFFFF;
    step();
    step();
    chk("rst_btn", {btn1, btn2, btn3, btn4}, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_evt", {ev.evt_valid, cur_evt()}, 0);
    do_reset();

    // first-event latency and frame_tick pulse
    gpw[0] = 16'hFFFE;
    frame();
    chk("lat_btn_early", btn1, 0);
    gp_data_ready = 1'b1;
    step();
    chk("tick_on", frame_tick, 1);
    chk("lat_v0", ev.evt_valid, 0);
    gp_data_ready = 1'b0;
    step();
    chk("tick_off", frame_tick, 0);
    chk("lat_btn", btn1, 16'h0001);
    chk("lat_v1", ev.evt_valid, 0);
    step();
    chk("lat_v2", ev.evt_valid, 1);
    chk("lat_evt", cur_evt(), {2'd0, 4'd0, 1'b1});
    ev.evt_ready = 1'b1;
    step();
    chk("acc_drop", ev.evt_valid, 0);
    ev.evt_ready = 1'b0;
    step();
    chk("no_repeat", ev.evt_valid, 0);

    // vector table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      gpw[vecs[i].pad] = vecs[i].w;
      repeat (vecs[i].nfr) frame();
      ev.evt_ready = 1'b1;
      collect(got, e);
      ev.evt_ready = 1'b0;
      chk($sformatf("vec%0d_got", i), got, vecs[i].ev);
      if (vecs[i].ev)
        chk($sformatf("vec%0d_evt", i), e,
            {vecs[i].ep, vecs[i].eb, vecs[i].epr});
      chk($sformatf("vec%0d_btn", i), get_btn(vecs[i].pad), vecs[i].ebtn);
    end

    // round-robin fairness and two-cycle spacing
    do_reset();
    fp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    fb = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd8, 4'd8, 4'd8, 4'd8};
    ev.evt_ready = 1'b1;
    for (int p = 0; p < 4; p++) gpw[p] = 16'hFEF7;
    frame();
    frame();
    n = 0;
    last = -1;
    for (int c = 0; c < 40; c++) begin
      if (ev.evt_valid && n < 8) begin
        chk($sformatf("fair%0d", n), cur_evt(), {fp[n], fb[n], 1'b1});
        if (last >= 0) chk("fair_gap", c - last, 2);
        last = c;
        n++;
      end
      step();
    end
    chk("fair_count", n, 8);
    ev.evt_ready = 1'b0;

    // backpressure: hold while frames arrive, then release follows
    do_reset();
    gpw[0] = 16'hFFEF;
    frame();
    frame();
    step();
    chk("bp_first", {ev.evt_valid, cur_evt()}, {1'b1, 2'd0, 4'd4, 1'b1});
    for (int i = 0; i < 5; i++) begin
      gpw[0] = (i < 3) ? 16'hFFEF : 16'hFFFF;
      frame();
      chk("bp_hold", {ev.evt_valid, cur_evt()}, {1'b1, 2'd0, 4'd4, 1'b1});
    end
    chk("bp_btn", btn1, 0);
    ev.evt_ready = 1'b1;
    step();
    collect(got, e);
    ev.evt_ready = 1'b0;
    chk("bp_rel_got", got, 1);
    chk("bp_rel_evt", e, {2'd0, 4'd4, 1'b0});

    // reset during PRESENT with gp_data_ready held high
    do_reset();
    gpw[0] = 16'hFFFE;
    frame();
    frame();
    step();
    chk("rst_pre", ev.evt_valid, 1);
    gp_data_ready = 1'b1;
    rst = 1'b1;
    step();
    chk("rst_drop", ev.evt_valid, 0);
    chk("rst_btn1", btn1, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_tick", frame_tick, 0);
    end
    gp_data_ready = 1'b0;
    step();
    gp_data_ready = 1'b1;
    step();
    chk("rst_tick_again", frame_tick, 1);
    gp_data_ready = 1'b0;
    step();
    chk("rst_no_evt", ev.evt_valid, 0);

    // randomized frames against the reference model
    do_reset();
    for (int f = 0; f < 60; f++) begin
      for (int p = 0; p < 4; p++)
        gpw[p] = gpw[p] ^ 16'($urandom & $urandom & $urandom);
      frame();
      m_frame();
      for (int p = 0; p < 4; p++)
        chk($sformatf("rnd_btn%0d", p), get_btn(p), m_word(p));
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
